cpu_d2e_pipe_ctrl: RTL and testbench

//  Decode->Execute pipeline register plus stall/bubble controller for the MCS8 pipe.

---
 rtl/cpu_d2e_pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_d2e_pipe_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_d2e_pipe_ctrl.sv
// rtl/cpu_d2e_pipe_ctrl.sv - Decode->Execute pipeline register with stall/bubble/HALT control (optional counter: CPU_BUBBLE_CNT_EN)
module cpu_d2e_pipe_ctrl #(
    parameter int OPW  = 8,
    parameter int IMMW = 16,
    parameter int CNTW = 16
) (
    input  logic            CLK_I,
    input  logic            RST_N_I,
    input  logic            D_VALID_I,
    input  logic [OPW-1:0]  D_OPCODE_I,
    input  logic [IMMW-1:0] D_IMM_I,
    input  logic [2:0]      D_DST_I,
    input  logic            D_DSTR_CS_C_I,
    input  logic            D_DSTR_CS_S_I,
    input  logic            D_DSTR_CS_E_I,
    input  logic            D_DSTR_CS_M_I,
    input  logic            D_HLT_I,
    input  logic            BUBBLE_DATA_I,
    input  logic            FLUSH_I,
    input  logic            INTR_I,
    output logic            E_VALID_O,
    output logic [OPW-1:0]  E_OPCODE_O,
    output logic [IMMW-1:0] E_IMM_O,
    output logic [2:0]      E_DST_O,
    output logic            E_DSTR_CS_C_O,
    output logic            E_DSTR_CS_S_O,
    output logic            E_DSTR_CS_E_O,
    output logic            E_DSTR_CS_M_O,
    output logic            STALL_F_O,
    output logic            STALL_D_O,
    output logic            HALTED_O,
    output logic [CNTW-1:0] BUBBLE_CNT_O
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t          state_q;
    logic            e_valid_q;
    logic [OPW-1:0]  e_opcode_q;
    logic [IMMW-1:0] e_imm_q;
    logic [2:0]      e_dst_q;
    logic [3:0]      e_cs_q;
    logic            haz;
    logic            stall;

    assign haz = D_VALID_I & BUBBLE_DATA_I;

    // Stalls depend only on state and D-side inputs, never on the E registers.
    assign stall = RST_N_I & ((state_q == ST_HALT) ||
                              ((state_q == ST_RUN) && !FLUSH_I && haz));

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= ST_RUN;
            e_valid_q  <= 1'b0;
            e_opcode_q <= '0;
            e_imm_q    <= '0;
            e_dst_q    <= '0;
            e_cs_q     <= '0;
        end else begin
            e_valid_q  <= 1'b0;
            e_opcode_q <= '0;
            e_imm_q    <= '0;
            e_dst_q    <= '0;
            e_cs_q     <= '0;
            case (state_q)
                ST_RUN: begin
                    // Invalid D loads as a full bubble so no class flag can match downstream.
                    if (!FLUSH_I && !haz && D_VALID_I) begin
                        e_valid_q  <= 1'b1;
                        e_opcode_q <= D_OPCODE_I;
                        e_imm_q    <= D_IMM_I;
                        e_dst_q    <= D_DST_I;
                        e_cs_q     <= {D_DSTR_CS_M_I, D_DSTR_CS_E_I,
                                       D_DSTR_CS_S_I, D_DSTR_CS_C_I};
                        if (D_HLT_I) begin
                            state_q <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (FLUSH_I || INTR_I) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

`ifdef CPU_BUBBLE_CNT_EN
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_RUN) && haz && !FLUSH_I && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign BUBBLE_CNT_O = cnt_q;
`else
    assign BUBBLE_CNT_O = '0;
`endif

    assign E_VALID_O     = e_valid_q;
    assign E_OPCODE_O    = e_opcode_q;
    assign E_IMM_O       = e_imm_q;
    assign E_DST_O       = e_dst_q;
    assign E_DSTR_CS_C_O = e_cs_q[0];
    assign E_DSTR_CS_S_O = e_cs_q[1];
    assign E_DSTR_CS_E_O = e_cs_q[2];
    assign E_DSTR_CS_M_O = e_cs_q[3];
    assign STALL_F_O     = stall;
    assign STALL_D_O     = stall;
    assign HALTED_O      = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_d2e_pipe_ctrl.sv
// tb/tb_cpu_d2e_pipe_ctrl.sv - directed self-checking bench for cpu_d2e_pipe_ctrl
module tb_cpu_d2e_pipe_ctrl;

    localparam int OPW  = 8;
    localparam int IMMW = 16;
    localparam int CNTW = 2;
`ifdef CPU_BUBBLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            d_valid, d_hlt, bubble, flush, intr;
    logic [OPW-1:0]  d_opcode;
    logic [IMMW-1:0] d_imm;
    logic [2:0]      d_dst;
    logic            d_cs_c, d_cs_s, d_cs_e, d_cs_m;
    logic            e_valid;
    logic [OPW-1:0]  e_opcode;
    logic [IMMW-1:0] e_imm;
    logic [2:0]      e_dst;
    logic            e_cs_c, e_cs_s, e_cs_e, e_cs_m;
    logic            stall_f, stall_d, halted;
    logic [CNTW-1:0] bcnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_d2e_pipe_ctrl #(.OPW(OPW), .IMMW(IMMW), .CNTW(CNTW)) dut (
        .CLK_I(clk), .RST_N_I(rst_n),
        .D_VALID_I(d_valid), .D_OPCODE_I(d_opcode), .D_IMM_I(d_imm), .D_DST_I(d_dst),
        .D_DSTR_CS_C_I(d_cs_c), .D_DSTR_CS_S_I(d_cs_s),
        .D_DSTR_CS_E_I(d_cs_e), .D_DSTR_CS_M_I(d_cs_m),
        .D_HLT_I(d_hlt), .BUBBLE_DATA_I(bubble), .FLUSH_I(flush), .INTR_I(intr),
        .E_VALID_O(e_valid), .E_OPCODE_O(e_opcode), .E_IMM_O(e_imm), .E_DST_O(e_dst),
        .E_DSTR_CS_C_O(e_cs_c), .E_DSTR_CS_S_O(e_cs_s),
        .E_DSTR_CS_E_O(e_cs_e), .E_DSTR_CS_M_O(e_cs_m),
        .STALL_F_O(stall_f), .STALL_D_O(stall_d), .HALTED_O(halted),
        .BUBBLE_CNT_O(bcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [7:0] op, input logic [15:0] imm,
                         input logic [2:0] dst, input logic [3:0] cs, input logic hlt);
        d_valid = v; d_opcode = op; d_imm = imm; d_dst = dst;
        {d_cs_m, d_cs_e, d_cs_s, d_cs_c} = cs;
        d_hlt = hlt;
    endtask

    initial begin
        rst_n = 1'b0; bubble = 1'b1; flush = 1'b0; intr = 1'b0;
        set_d(1'b1, 8'h11, 16'h2222, 3'd1, 4'b0100, 1'b0);
        #12;
        chk("rst_e_valid", {31'd0, e_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_stall_f", {31'd0, stall_f}, 32'd0);
        chk("rst_cnt", {30'd0, bcnt}, 32'd0);
        tick();
        rst_n = 1'b1; bubble = 1'b0;

        // Plain advance
        set_d(1'b1, 8'hA5, 16'h1234, 3'd3, 4'b0100, 1'b0);
        #1 chk("adv_stall_d", {31'd0, stall_d}, 32'd0);
        tick();
        chk("adv_e_valid", {31'd0, e_valid}, 32'd1);
        chk("adv_e_dst", {29'd0, e_dst}, 32'd3);
        chk("adv_e_cs_e", {31'd0, e_cs_e}, 32'd1);
        chk("adv_e_cs_m", {31'd0, e_cs_m}, 32'd0);
        chk("adv_e_opcode", {24'd0, e_opcode}, 32'hA5);
        chk("adv_e_imm", {16'd0, e_imm}, 32'h1234);

        // Load-use hazard: one bubble, then retry
        set_d(1'b1, 8'h3C, 16'h0055, 3'd5, 4'b1000, 1'b0);
        bubble = 1'b1;
        #1 chk("lu_stall_f", {31'd0, stall_f}, 32'd1);
        chk("lu_stall_d", {31'd0, stall_d}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, e_valid}, 32'd0);
        chk("lu_bubble_dst", {29'd0, e_dst}, 32'd0);
        chk("lu_cnt", {30'd0, bcnt}, cexp(1));
        bubble = 1'b0;
        #1 chk("lu_retry_stall", {31'd0, stall_f}, 32'd0);
        tick();
        chk("lu_retry_valid", {31'd0, e_valid}, 32'd1);
        chk("lu_retry_dst", {29'd0, e_dst}, 32'd5);
        chk("lu_retry_cs_m", {31'd0, e_cs_m}, 32'd1);
        chk("lu_retry_opcode", {24'd0, e_opcode}, 32'h3C);

        // Flush beats hazard
        flush = 1'b1; bubble = 1'b1;
        #1 chk("fl_stall_f", {31'd0, stall_f}, 32'd0);
        tick();
        chk("fl_e_valid", {31'd0, e_valid}, 32'd0);
        chk("fl_e_cs_m", {31'd0, e_cs_m}, 32'd0);
        chk("fl_cnt", {30'd0, bcnt}, cexp(1));
        flush = 1'b0;

        // Invalid D with hazard flag: no stall, bubble with clean class flags
        set_d(1'b0, 8'h77, 16'h9999, 3'd6, 4'b0100, 1'b0);
        #1 chk("nv_stall_f", {31'd0, stall_f}, 32'd0);
        tick();
        chk("nv_e_valid", {31'd0, e_valid}, 32'd0);
        chk("nv_e_cs_e", {31'd0, e_cs_e}, 32'd0);
        chk("nv_cnt", {30'd0, bcnt}, cexp(1));

        // Counter saturation at 3 (CNTW=2)
        set_d(1'b1, 8'h42, 16'h0001, 3'd2, 4'b0010, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", k), {30'd0, bcnt}, cexp(k > 3 ? 3 : k));
        end
        bubble = 1'b0;

        // Interrupt in RUN is ignored
        intr = 1'b1;
        tick();
        chk("intr_run_halted", {31'd0, halted}, 32'd0);
        intr = 1'b0;

        // HLT enters E and the FSM halts
        set_d(1'b1, 8'h76, 16'h0000, 3'd0, 4'b0000, 1'b1);
        tick();
        chk("hlt_e_valid", {31'd0, e_valid}, 32'd1);
        chk("hlt_e_opcode", {24'd0, e_opcode}, 32'h76);
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        set_d(1'b1, 8'h12, 16'h0003, 3'd4, 4'b0100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("halt_stall_%0d", k), {31'd0, stall_f & stall_d}, 32'd1);
            tick();
            chk($sformatf("halt_flag_%0d", k), {31'd0, halted}, 32'd1);
            chk($sformatf("halt_bubble_%0d", k), {31'd0, e_valid}, 32'd0);
        end
        intr = 1'b1;
        tick();
        intr = 1'b0;
        chk("intr_halted", {31'd0, halted}, 32'd0);
        chk("intr_stall", {31'd0, stall_f}, 32'd0);
        tick();
        chk("intr_resume_valid", {31'd0, e_valid}, 32'd1);
        chk("intr_resume_dst", {29'd0, e_dst}, 32'd4);

        // Async reset in HALT with a valid HLT in E
        set_d(1'b1, 8'h76, 16'h0000, 3'd7, 4'b0100, 1'b1);
        tick();
        chk("ar_pre_halted", {31'd0, halted}, 32'd1);
        chk("ar_pre_valid", {31'd0, e_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("ar_e_valid", {31'd0, e_valid}, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_stall", {31'd0, stall_f}, 32'd0);
        chk("ar_cnt", {30'd0, bcnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_d(1'b1, 8'h21, 16'h0ABC, 3'd2, 4'b0001, 1'b0);
        #1 chk("ar_run_stall", {31'd0, stall_d}, 32'd0);
        tick();
        chk("ar_run_valid", {31'd0, e_valid}, 32'd1);
        chk("ar_run_cs_c", {31'd0, e_cs_c}, 32'd1);
        chk("ar_run_halted", {31'd0, halted}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
